// File: rtl/bus_sync_pkg.sv
// Shared constants and the edge-qualification helper for the bus synchroniser.
package bus_sync_pkg;

  localparam int unsigned EN_MODE_LEVEL  = 0;
  localparam int unsigned EN_MODE_TOGGLE = 0 + 1;
  localparam int unsigned NUM_STAGES_MIN = 2;
  localparam int unsigned NUM_STAGES_MAX = 4;

  // Level mode qualifies on a rising edge; toggle mode qualifies on any edge.
  function automatic logic qualify_edge(input int unsigned mode, input logic cur,
                                        input logic prev);
    return (mode == EN_MODE_TOGGLE) ? (cur ^ prev) : (cur & ~prev);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Generic 1-bit multi-flop synchroniser with synchronous active-high reset.
module sync_chain #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic sync_clk,
  input  logic sync_rst,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] stage_q;

  always_ff @(posedge sync_clk) begin
    if (sync_rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[NUM_STAGES-2:0], d};
    end
  end

  assign q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync.sv
// Multi-bit bus transfer qualified by a synchronised enable, with a saturating transfer counter.
module bus_sync
  import bus_sync_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned EN_MODE    = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 sync_clk,
  input  logic                 sync_rst,
  input  logic [DATA_SIZE-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [DATA_SIZE-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic [CNT_W-1:0]     xfer_cnt
);

  if (NUM_STAGES < NUM_STAGES_MIN || NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
    $error("bus_sync: NUM_STAGES out of range");
  end
  if (EN_MODE != EN_MODE_LEVEL && EN_MODE != EN_MODE_TOGGLE) begin : g_bad_mode
    $error("bus_sync: EN_MODE must be 0 or 1");
  end
  if (DATA_SIZE < 1 || DATA_SIZE > 64) begin : g_bad_width
    $error("bus_sync: DATA_SIZE out of range");
  end

  logic                 chain_out;
  logic                 prev_q;
  logic                 qualify;
  logic [DATA_SIZE-1:0] bus_q, bus_d;
  logic                 pulse_q, pulse_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_sync_chain (
    .sync_clk(sync_clk),
    .sync_rst(sync_rst),
    .d       (bus_enable),
    .q       (chain_out)
  );

  assign qualify = qualify_edge(EN_MODE, chain_out, prev_q);

  always_comb begin
    bus_d   = bus_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (qualify) begin
      bus_d   = unsync_bus;
      pulse_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sync_clk) begin
    if (sync_rst) begin
      prev_q  <= 1'b0;
      bus_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= chain_out;
      bus_q   <= bus_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_bus     = bus_q;
  assign enable_pulse = pulse_q;
  assign xfer_cnt     = cnt_q;

endmodule

// File: tb/tb_bus_sync.sv
// Scoreboard bench: stimulus pushes expected captures, per-DUT monitors pop on enable_pulse.
module tb_bus_sync;

  typedef struct {
    logic [7:0] data;
    int         cnt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  // DUT0: level mode, 2 stages, 2-bit counter. DUT1: toggle mode, 3 stages.
  logic       rst0, en0, rst1, en1;
  logic [7:0] din0, din1, dout0, dout1;
  logic       pulse0, pulse1;
  logic [1:0] cnt0;
  logic [7:0] cnt1;

  exp_t       q0[$];
  exp_t       q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_sync #(
    .DATA_SIZE (8),
    .NUM_STAGES(2),
    .EN_MODE   (0),
    .CNT_W     (2)
  ) dut0 (
    .sync_clk    (clk),
    .sync_rst    (rst0),
    .unsync_bus  (din0),
    .bus_enable  (en0),
    .sync_bus    (dout0),
    .enable_pulse(pulse0),
    .xfer_cnt    (cnt0)
  );

  bus_sync #(
    .DATA_SIZE (8),
    .NUM_STAGES(3),
    .EN_MODE   (1),
    .CNT_W     (8)
  ) dut1 (
    .sync_clk    (clk),
    .sync_rst    (rst1),
    .unsync_bus  (din1),
    .bus_enable  (en1),
    .sync_bus    (dout1),
    .enable_pulse(pulse1),
    .xfer_cnt    (cnt1)
  );

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (pulse0) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected pulse", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 pulse cycle", cyc, e.cyc);
        check("dut0 sync_bus", dout0, e.data);
        check("dut0 xfer_cnt", cnt0, e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    if (pulse1) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected pulse", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("dut1 pulse cycle", cyc, e.cyc);
        check("dut1 sync_bus", dout1, e.data);
        check("dut1 xfer_cnt", cnt1, e.cnt);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 transfer: enable sampled at edge cyc+1, visible after edge cyc+3.
  task automatic xfer0(input logic [7:0] d, input int exp_cnt, input int hold);
    din0 = d;
    en0  = 1'b1;
    q0.push_back('{data: d, cnt: exp_cnt, cyc: cyc + 3});
    wait_cycles(hold);
    en0 = 1'b0;
    wait_cycles(5);
  endtask

  task automatic toggle1(input logic [7:0] d, input int exp_cnt);
    din1 = d;
    en1  = ~en1;
    q1.push_back('{data: d, cnt: exp_cnt, cyc: cyc + 4});
    wait_cycles(8);
  endtask

  initial begin
    rst0 = 1'b1; en0 = 1'b0; din0 = 8'h00;
    rst1 = 1'b1; en1 = 1'b0; din1 = 8'h00;
    wait_cycles(3);
    check("reset sync_bus0", dout0, 0);
    check("reset pulse0", pulse0, 0);
    check("reset cnt0", cnt0, 0);
    check("reset sync_bus1", dout1, 0);
    check("reset pulse1", pulse1, 0);
    check("reset cnt1", cnt1, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    wait_cycles(2);

    // Long-held level enable gives exactly one pulse, then saturation 1,2,3,3,3.
    xfer0(8'hA5, 1, 10);
    check("held sync_bus0", dout0, 8'hA5);
    xfer0(8'h01, 2, 3);
    xfer0(8'h02, 3, 3);
    xfer0(8'h03, 3, 3);
    xfer0(8'h04, 3, 3);
    check("saturated cnt0", cnt0, 3);

    // Data isolation: bus churns with enable low.
    for (int i = 0; i < 10; i++) begin
      din0 = 8'h10 + 8'(i * 7);
      wait_cycles(1);
      check("isolation sync_bus0", dout0, 8'h04);
    end

    // Reset with enable in flight; still-high enable gives one pulse after release.
    din0 = 8'h5A;
    en0  = 1'b1;
    rst0 = 1'b1;
    wait_cycles(1);
    check("midreset sync_bus0", dout0, 0);
    check("midreset pulse0", pulse0, 0);
    check("midreset cnt0", cnt0, 0);
    rst0 = 1'b0;
    q0.push_back('{data: 8'h5A, cnt: 1, cyc: cyc + 3});
    wait_cycles(8);
    en0 = 1'b0;
    wait_cycles(5);

    // Toggle mode: both edge directions produce a pulse.
    toggle1(8'h11, 1);
    toggle1(8'h22, 2);
    toggle1(8'h33, 3);
    check("final sync_bus1", dout1, 8'h33);
    check("final cnt1", cnt1, 3);

    check("dut0 pulses outstanding", q0.size(), 0);
    check("dut1 pulses outstanding", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
